// File: rtl/issue_stage_sequencer_if.sv
// issue_stage_sequencer_if: control/status bundle between the core controller and the issue stage sequencer
interface issue_stage_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = $clog2(NUM_STAGES),
  parameter int RETIRE_W   = 32
);
  logic                  start;
  logic                  stall;
  logic                  flush;
  logic                  halt;
  logic                  instr_valid;
  logic                  instr_req;
  logic                  issue_reg_en;
  logic [STAGE_W-1:0]    stage;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  retire;
  logic [RETIRE_W-1:0]   retired_count;
  logic                  busy;
  logic                  halted;
  modport master (
    output start, stall, flush, halt, instr_valid,
    input  instr_req, issue_reg_en, stage, stage_en, retire, retired_count, busy, halted
  );
  modport slave (
    input  start, stall, flush, halt, instr_valid,
    output instr_req, issue_reg_en, stage, stage_en, retire, retired_count, busy, halted
  );
endinterface

// File: rtl/issue_stage_sequencer.sv
// issue_stage_sequencer: multicycle stage counter with fetch handshake, stall/flush/halt and retire counting
module issue_stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = $clog2(NUM_STAGES),
  parameter int RETIRE_W   = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  issue_stage_sequencer_if.slave io
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALTED} state_t;
  localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES - 1);
  state_t              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [RETIRE_W-1:0] cnt_q, cnt_d;
  logic                hp_q, hp_d;
  logic                busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      hp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
    end
  end
  always_comb begin
    state_d         = state_q;
    stage_d         = stage_q;
    cnt_d           = cnt_q;
    hp_d            = hp_q;
    io.instr_req    = 1'b0;
    io.issue_reg_en = 1'b0;
    io.retire       = 1'b0;
    case (state_q)
      IDLE, HALTED: begin
        if (io.start) begin
          state_d = FETCH;
          stage_d = '0;
          hp_d    = 1'b0;
        end
      end
      FETCH: begin
        io.instr_req    = 1'b1;
        hp_d            = hp_q | io.halt;
        io.issue_reg_en = io.instr_valid & ~io.stall & ~io.flush;
        if (io.issue_reg_en) begin
          state_d = EXEC;
          stage_d = STAGE_W'(1);
        end
      end
      EXEC: begin
        hp_d = hp_q | io.halt;
        if (io.flush) begin
          state_d = FETCH;
          stage_d = '0;
        end else if (!io.stall) begin
          if (stage_q == LAST) begin
            io.retire = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            stage_d   = '0;
            state_d   = (hp_q | io.halt) ? HALTED : FETCH;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end
      end
    endcase
  end
  assign busy             = (state_q == FETCH) || (state_q == EXEC);
  assign io.busy          = busy;
  assign io.halted        = state_q == HALTED;
  assign io.stage         = stage_q;
  assign io.stage_en      = busy ? (NUM_STAGES'(1) << stage_q) : '0;
  assign io.retired_count = cnt_q;
endmodule

// File: tb/tb_issue_stage_sequencer.sv
// tb_issue_stage_sequencer: directed per-cycle expectations queued by stimulus and checked by a negedge monitor
module tb_issue_stage_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  issue_stage_sequencer_if #(.NUM_STAGES(5), .RETIRE_W(32)) b ();
  issue_stage_sequencer_if #(.NUM_STAGES(5), .RETIRE_W(4))  w ();
  issue_stage_sequencer #(.NUM_STAGES(5), .RETIRE_W(32)) dut (.clk(clk), .rst_n(rst_n), .io(b));
  issue_stage_sequencer #(.NUM_STAGES(5), .RETIRE_W(4))  dut_w (.clk(clk), .rst_n(rst_n), .io(w));
  assign w.start       = b.start;
  assign w.stall       = b.stall;
  assign w.flush       = b.flush;
  assign w.halt        = b.halt;
  assign w.instr_valid = b.instr_valid;
  localparam logic [4:0] START = 5'b10000, STALL = 5'b01000, FLUSH = 5'b00100, HALT = 5'b00010, VALID = 5'b00001;
  localparam logic [4:0] F_IDLE = 5'b00000, F_FETCH = 5'b11010, F_WAIT = 5'b10010, F_EXEC = 5'b00010;
  localparam logic [4:0] F_RET = 5'b00110, F_HALT = 5'b00001;
  typedef struct {
    string      name;
    logic [2:0] st;
    logic [4:0] fl;
    int         cnt;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  task automatic chk(input exp_t e);
    logic [4:0] afl;
    logic [4:0] een;
    logic [3:0] ew;
    logic [31:0] ec;
    afl = {b.instr_req, b.issue_reg_en, b.retire, b.busy, b.halted};
    een = e.fl[1] ? (5'b00001 << e.st) : 5'b00000;
    ec  = e.cnt;
    ew  = ec[3:0];
    tests++;
    if (b.stage !== e.st || b.stage_en !== een || afl !== e.fl || b.retired_count !== ec || w.retired_count !== ew) begin
      fails++;
      $display("FAIL %s: stage=%0d en=%b req/iss/ret/busy/hlt=%b cnt=%0d wcnt=%0d, expected stage=%0d en=%b flags=%b cnt=%0d wcnt=%0d",
               e.name, b.stage, b.stage_en, afl, b.retired_count, w.retired_count, e.st, een, e.fl, ec, ew);
    end
  endtask
  always @(negedge clk) if (q.size() != 0) chk(q.pop_front());
  task automatic put(input string n, input logic [4:0] in, input logic [2:0] st, input logic [4:0] fl, input int cnt);
    exp_t e;
    {b.start, b.stall, b.flush, b.halt, b.instr_valid} = in;
    e.name = n;
    e.st   = st;
    e.fl   = fl;
    e.cnt  = cnt;
    q.push_back(e);
  endtask
  task automatic step(input string n, input logic [4:0] in, input logic [2:0] st, input logic [4:0] fl, input int cnt);
    put(n, in, st, fl, cnt);
    @(posedge clk);
    #1;
  endtask
  task automatic exec_run(input string n, input int cnt);
    for (int s = 1; s < 4; s++) step(n, VALID, 3'(s), F_EXEC, cnt);
    step({n, "_retire"}, VALID, 3'd4, F_RET, cnt);
  endtask
  initial begin
    exp_t e;
    {b.start, b.stall, b.flush, b.halt, b.instr_valid} = '0;
    @(posedge clk);
    #1;
    step("in_reset", START | VALID, 0, F_IDLE, 0);
    rst_n = 1'b1;
    step("idle_start", START | VALID, 0, F_IDLE, 0);
    for (int i = 0; i < 3; i++) begin
      step("run_fetch", VALID, 0, F_FETCH, i);
      exec_run("run", i);
    end
    for (int i = 0; i < 3; i++) step("fetch_wait", 5'b0, 0, F_WAIT, 3);
    step("fetch_accept", VALID, 0, F_FETCH, 3);
    step("pre_stall", VALID, 1, F_EXEC, 3);
    step("stall_1", STALL | VALID, 2, F_EXEC, 3);
    step("stall_2", STALL | VALID, 2, F_EXEC, 3);
    step("stall_end", VALID, 2, F_EXEC, 3);
    step("post_stall", VALID, 3, F_EXEC, 3);
    step("stall_retire", VALID, 4, F_RET, 3);
    step("f_fetch", VALID, 0, F_FETCH, 4);
    step("f_s1", VALID, 1, F_EXEC, 4);
    step("f_s2", VALID, 2, F_EXEC, 4);
    step("flush_s3", FLUSH | VALID, 3, F_EXEC, 4);
    step("after_flush", VALID, 0, F_FETCH, 4);
    step("fs_s1", VALID, 1, F_EXEC, 4);
    step("flush_stall_s2", FLUSH | STALL | VALID, 2, F_EXEC, 4);
    step("fetch_stall", STALL | VALID, 0, F_WAIT, 4);
    step("fetch_flush", FLUSH | VALID, 0, F_WAIT, 4);
    step("fetch_ok", VALID, 0, F_FETCH, 4);
    step("halt_s1", HALT | VALID, 1, F_EXEC, 4);
    step("h_s2", VALID, 2, F_EXEC, 4);
    step("h_s3", VALID, 3, F_EXEC, 4);
    step("h_retire", VALID, 4, F_RET, 4);
    step("halted", VALID, 0, F_HALT, 5);
    step("halted_start", START | VALID, 0, F_HALT, 5);
    step("resume_fetch", VALID, 0, F_FETCH, 5);
    step("r_s1", VALID, 1, F_EXEC, 5);
    step("r_s2", VALID, 2, F_EXEC, 5);
    step("r_s3", VALID, 3, F_EXEC, 5);
    step("halt_at_retire", HALT | VALID, 4, F_RET, 5);
    step("halted2", VALID, 0, F_HALT, 6);
    step("halted2_start", START | VALID, 0, F_HALT, 6);
    step("halt_in_fetch", HALT | VALID, 0, F_FETCH, 6);
    exec_run("hf", 6);
    step("halted3", VALID, 0, F_HALT, 7);
    step("halted3_start", START | VALID, 0, F_HALT, 7);
    step("ar_fetch", VALID, 0, F_FETCH, 7);
    step("ar_s1", VALID, 1, F_EXEC, 7);
    step("ar_s2", VALID, 2, F_EXEC, 7);
    put("ar_s3", VALID, 3, F_EXEC, 7);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    e.name = "async_reset";
    e.st   = 0;
    e.fl   = F_IDLE;
    e.cnt  = 0;
    chk(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("w_start", START | VALID, 0, F_IDLE, 0);
    for (int i = 0; i < 16; i++) begin
      step("w_fetch", VALID, 0, F_FETCH, i);
      exec_run("w", i);
    end
    step("w_wrapped", VALID, 0, F_FETCH, 16);
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
